// File: rtl/pwm_deadtime_pkg.sv
// Shared types and constants for the PWM dead-time stage.
package pwm_pkg;

    localparam int DT_W_DEFAULT = 16;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        L_ON  = 3'd1,
        DT_LH = 3'd2,
        H_ON  = 3'd3,
        DT_HL = 3'd4,
        FAULT = 3'd5
    } pwm_dt_state_t;

endpackage

// File: rtl/pwm_deadtime_if.sv
// Control/status bundle between the PWM core side and the dead-time stage.
interface pwm_deadtime_if #(
    parameter int DT_W = pwm_pkg::DT_W_DEFAULT
);
    logic            en;
    logic            pwm_in;
    logic [DT_W-1:0] dt_rise;
    logic [DT_W-1:0] dt_fall;
    logic            pol_h;
    logic            pol_l;
    logic            fault;
    logic            fault_clr;
    logic            out_h;
    logic            out_l;
    logic            dead;
    logic            fault_latched;

    modport master (
        output en, pwm_in, dt_rise, dt_fall, pol_h, pol_l, fault, fault_clr,
        input  out_h, out_l, dead, fault_latched
    );

    modport slave (
        input  en, pwm_in, dt_rise, dt_fall, pol_h, pol_l, fault, fault_clr,
        output out_h, out_l, dead, fault_latched
    );
endinterface

// File: rtl/pwm_deadtime.sv
// Complementary high/low gate pair with programmable dead time, pulse
// swallowing, per-output polarity and a latched fault shutdown.
module pwm_deadtime
    import pwm_pkg::*;
#(
    parameter int DT_W = DT_W_DEFAULT
) (
    input logic          clk,
    input logic          rst_n,
    pwm_deadtime_if.slave bus
);

    pwm_dt_state_t   state_q, state_d;
    logic [DT_W-1:0] cnt_q, cnt_d;
    logic            pwm_q;
    logic            h_act_q, l_act_q, dead_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pwm_q   <= 1'b0;
            h_act_q <= 1'b0;
            l_act_q <= 1'b0;
            dead_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pwm_q   <= bus.pwm_in;
            // Drive flags are decoded from next-state so they stay registered
            // yet change on the same edge as the state.
            h_act_q <= (state_d == H_ON);
            l_act_q <= (state_d == L_ON);
            dead_q  <= (state_d == DT_LH) || (state_d == DT_HL);
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (bus.fault) begin
            state_d = FAULT;
        end else if (!bus.en) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pwm_q) begin
                        state_d = DT_LH;
                        cnt_d   = bus.dt_rise;
                    end else begin
                        state_d = DT_HL;
                        cnt_d   = bus.dt_fall;
                    end
                end
                L_ON: begin
                    if (pwm_q) begin
                        state_d = DT_LH;
                        cnt_d   = bus.dt_rise;
                    end
                end
                DT_LH: begin
                    // A pulse that ends before the dead time expires never reaches out_h.
                    if (!pwm_q)             state_d = L_ON;
                    else if (cnt_q == '0)   state_d = H_ON;
                    else                    cnt_d   = cnt_q - DT_W'(1);
                end
                H_ON: begin
                    if (!pwm_q) begin
                        state_d = DT_HL;
                        cnt_d   = bus.dt_fall;
                    end
                end
                DT_HL: begin
                    if (pwm_q)              state_d = H_ON;
                    else if (cnt_q == '0)   state_d = L_ON;
                    else                    cnt_d   = cnt_q - DT_W'(1);
                end
                FAULT: begin
                    if (bus.fault_clr) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign bus.out_h         = h_act_q ^ bus.pol_h;
    assign bus.out_l         = l_act_q ^ bus.pol_l;
    assign bus.dead          = dead_q;
    assign bus.fault_latched = (state_q == FAULT);

endmodule
